// File: rtl/controle_reposicao_rolhas.sv
// controle_reposicao_rolhas
// Cork-supply controller for the wine conveyor line. Owns the magazine cork
// count and the reserve stock count, serves consumption requests from the
// process FSM, accepts operator stock additions, and runs an automatic refill
// sequence that pulses the cork dispenser actuator.
//
// Ports:
//   clk              - only clock; all state changes on its rising edge
//   reset            - asynchronous, active-low reset
//   dec_req          - single-cycle request to consume one cork
//   add_stock        - debounced operator level; each rising edge adds a unit
//   start_proc       - enables automatic refill while high
//   contagem         - magazine cork count (0..MAG_MAX)
//   estoque          - reserve stock units (0..STOCK_MAX)
//   dec_ack          - registered pulse: the consumption request was accepted
//   disp_acionado    - dispenser actuator drive
//   LED_Alarme       - low-supply alarm
//   rolha_disponivel - magazine not empty
module controle_reposicao_rolhas #(
  parameter int MAG_MAX     = 20,
  parameter int LOW_LEVEL   = 5,
  parameter int REFILL_QTY  = 15,
  parameter int STOCK_MAX   = 15,
  parameter int STOCK_INIT  = 5,
  parameter int DISP_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       dec_req,
  input  logic       add_stock,
  input  logic       start_proc,
  output logic [4:0] contagem,
  output logic [3:0] estoque,
  output logic       dec_ack,
  output logic       disp_acionado,
  output logic       LED_Alarme,
  output logic       rolha_disponivel
);

  localparam int TW = (DISP_CYCLES > 1) ? $clog2(DISP_CYCLES) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(DISP_CYCLES - 1);
  localparam logic [TW-1:0] TIMER_ONE  = TW'(1);
  localparam logic [TW-1:0] TIMER_ZERO = TW'(0);
  localparam logic [4:0]    MAG_RST    = 5'(MAG_MAX);
  localparam logic [4:0]    LOW_LVL    = 5'(LOW_LEVEL);
  localparam logic [5:0]    MAG_LIM    = 6'(MAG_MAX);
  localparam logic [5:0]    REFILL_W   = 6'(REFILL_QTY);
  localparam logic [3:0]    STK_RST    = 4'(STOCK_INIT);
  localparam logic [4:0]    STK_LIM    = 5'(STOCK_MAX);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DISPENSE = 2'd1,
    COMMIT   = 2'd2
  } state_t;

  state_t        state;
  state_t        state_next;
  logic [TW-1:0] timer;
  logic          add_sync;
  logic          add_prev;
  logic          add_rise;
  logic          dec_ok;
  logic          trigger;
  logic          commit;
  logic [5:0]    cont_sum;
  logic [4:0]    est_sum;
  logic [4:0]    cont_next;
  logic [3:0]    est_next;

  // An empty magazine silently drops the request (no ack, no wrap).
  assign dec_ok   = dec_req && (contagem != 5'd0);
  // Edge is taken between the two registered copies, so estoque moves one
  // edge after the switch is first sampled high.
  assign add_rise = add_sync && !add_prev;
  assign trigger  = start_proc && (contagem <= LOW_LVL) && (estoque != 4'd0);
  assign commit   = (state == COMMIT);

  assign disp_acionado    = (state == DISPENSE);
  assign rolha_disponivel = (contagem != 5'd0);
  assign LED_Alarme       = (contagem <= LOW_LVL) && (estoque == 4'd0);

  // Refill sequence state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  // Refill sequence next-state decode; DISPENSE cannot be aborted.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (trigger) state_next = DISPENSE;
        else         state_next = IDLE;
      end
      DISPENSE: begin
        if (timer == TIMER_LAST) state_next = COMMIT;
        else                     state_next = DISPENSE;
      end
      COMMIT:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Dispense timer: runs only in DISPENSE, held at zero elsewhere so it is
  // already cleared when a refill starts.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                 timer <= TIMER_ZERO;
    else if (state == DISPENSE) timer <= timer + TIMER_ONE;
    else                        timer <= TIMER_ZERO;
  end

  // Registered copies of the operator switch for rising-edge detection.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      add_sync <= 1'b0;
      add_prev <= 1'b0;
    end else begin
      add_sync <= add_stock;
      add_prev <= add_sync;
    end
  end

  // Next magazine and stock counts; refill, consumption and stock addition
  // combine in one update and saturate instead of wrapping.
  always_comb begin
    cont_sum = {1'b0, contagem};
    if (commit) cont_sum = cont_sum + REFILL_W;
    else        cont_sum = cont_sum;
    if (dec_ok) cont_sum = cont_sum - 6'd1;
    else        cont_sum = cont_sum;
    if (cont_sum > MAG_LIM) cont_sum = MAG_LIM;
    else                    cont_sum = cont_sum;
    cont_next = cont_sum[4:0];

    est_sum = {1'b0, estoque};
    if (add_rise) est_sum = est_sum + 5'd1;
    else          est_sum = est_sum;
    if (commit && (est_sum != 5'd0)) est_sum = est_sum - 5'd1;
    else                             est_sum = est_sum;
    if (est_sum > STK_LIM) est_sum = STK_LIM;
    else                   est_sum = est_sum;
    est_next = est_sum[3:0];
  end

  // Count registers and the acknowledge pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      contagem <= MAG_RST;
      estoque  <= STK_RST;
      dec_ack  <= 1'b0;
    end else begin
      contagem <= cont_next;
      estoque  <= est_next;
      dec_ack  <= dec_ok;
    end
  end

endmodule

// File: doc/controle_reposicao_rolhas.md
# controle_reposicao_rolhas

Cork-supply controller for the wine conveyor line. It owns the cork magazine count and the reserve stock count. It arbitrates three users of the magazine: cork consumption requests from the process FSM, manual stock additions from the operator switch, and its own automatic refill sequence. The refill sequence drives the cork dispenser actuator. The block sits between the process FSM (which consumes corks at sealing) and the seven-segment/alarm outputs, and runs on the slow clock-enable domain used by the FSMs.

## Interface

Parameters:
- MAG_MAX, 20: magazine capacity and magazine reset value.
- LOW_LEVEL, 5: refill threshold; a refill is allowed when contagem ≤ LOW_LEVEL.
- REFILL_QTY, 15: corks moved into the magazine per stock unit. LOW_LEVEL + REFILL_QTY ≤ MAG_MAX is required.
- STOCK_MAX, 15: reserve stock saturation value.
- STOCK_INIT, 5: reserve stock reset value.
- DISP_CYCLES, 4: number of cycles disp_acionado stays high per refill. Must be ≥ 1.

Ports:
- clk, input, 1: the only clock; all state changes on its rising edge.
- reset, input, 1: asynchronous, active-low reset (0 = reset).
- dec_req, input, 1: single-cycle request to consume one cork at sealing.
- add_stock, input, 1: debounced operator level; each rising edge adds one stock unit.
- start_proc, input, 1: enables automatic refill while high.
- contagem, output, 5: magazine cork count, range 0..MAG_MAX.
- estoque, output, 4: reserve stock units, range 0..STOCK_MAX.
- dec_ack, output, 1: registered pulse; the request was accepted.
- disp_acionado, output, 1: dispenser actuator drive.
- LED_Alarme, output, 1: low supply alarm.
- rolha_disponivel, output, 1: contagem ≠ 0.

## Operation

- Reset (asynchronous, immediate):
  - contagem = MAG_MAX, estoque = STOCK_INIT.
  - state = IDLE, timer = 0, add_stock edge register = 0.
  - dec_ack = 0, disp_acionado = 0.
  - Reset asserted mid-refill aborts the refill; no partial count change.
- FSM states: IDLE, DISPENSE, COMMIT.
  - IDLE → DISPENSE when start_proc = 1 && contagem ≤ LOW_LEVEL && estoque ≠ 0. Clear timer.
  - DISPENSE: disp_acionado = 1 (decoded from registered state). Timer increments. → COMMIT when timer = DISP_CYCLES−1.
  - DISPENSE ignores start_proc falling; the mechanism cannot abort.
  - COMMIT: contagem += REFILL_QTY and estoque −= 1, then → IDLE. disp_acionado = 0.
- Consumption, evaluated every cycle in every state:
  - If dec_req = 1 and contagem ≠ 0: contagem −= 1, and dec_ack pulses on the next cycle.
  - If contagem = 0: the request is dropped with no ack and no wrap.
- Simultaneous events:
  - dec_req in COMMIT: contagem_next = contagem + REFILL_QTY − 1. Acked if contagem ≠ 0 before the update.
  - add_stock edge in COMMIT: estoque is unchanged (the +1 and the −1 cancel).
  - add_stock edge with estoque = STOCK_MAX: estoque saturates and stays at STOCK_MAX. In COMMIT the result is still STOCK_MAX.
- Stock addition: a rising edge is detected against a registered copy of add_stock. Holding the switch high gives exactly one increment.
- Combinational outputs from registers:
  - rolha_disponivel = (contagem ≠ 0).
  - LED_Alarme = (contagem ≤ LOW_LEVEL) && (estoque = 0).
- Arithmetic: contagem is never below 0 or above MAG_MAX; estoque is never below 0 or above STOCK_MAX. No modulo wrap anywhere.

## Timing

- dec_req sampled at edge k: contagem updates at edge k; dec_ack is high for the cycle after edge k.
- add_stock rising between edges k−1 and k: estoque updates at edge k+1 (one edge-register stage).
- Refill trigger seen at edge k:
  - disp_acionado is high for edges k..k+DISP_CYCLES (exactly DISP_CYCLES cycles).
  - COMMIT occupies the next cycle.
  - contagem and estoque update at edge k+DISP_CYCLES+1.
- Back-to-back refills: at least one IDLE cycle separates them. The trigger is re-evaluated in IDLE.
- All outputs are stable between edges. No combinational path from inputs to outputs.

## Test plan

- Reset: hold reset = 0, then release. Required: contagem = 20, estoque = 5, rolha_disponivel = 1, LED_Alarme = 0, disp_acionado = 0, dec_ack = 0.
- Consume then refill: with start_proc = 0, apply 15 dec_req pulses. Required: contagem = 5 and no refill. Then raise start_proc. Required: disp_acionado high for exactly 4 cycles, then contagem = 20 and estoque = 4, DISP_CYCLES+1 edges after the trigger.
- Collisions in COMMIT: with contagem = 5, pulse dec_req in the COMMIT cycle. Required: contagem = 19, dec_ack = 1. With add_stock rising in COMMIT and estoque = 4: estoque stays 4.
- Exhaustion: set estoque to 0, then apply 20 dec_req pulses. Required: contagem = 0, rolha_disponivel = 0, LED_Alarme = 1, no disp_acionado. A further dec_req gives no dec_ack and contagem stays 0.
- Stock add: hold add_stock high for 10 cycles. Required: estoque +1 only. Repeating edges up to the limit gives estoque = 15, and the next edge leaves it at 15.
- Mid-refill reset: assert reset on the second DISPENSE cycle. Required: disp_acionado = 0 immediately, contagem = 20, estoque = 5, state IDLE after release.
